// File: rtl/peripheral_noc_pkg.sv
// ---------------------------------------------------------------------------
// peripheral_noc_pkg
// Shared definitions for the NoC endpoint packet transmitter:
//   - CLASS_WIDTH    : width of the packet class field in the header flit
//   - HDR_MAX_WIDTH  : working width of the header builder (upper bound on
//                      FLIT_WIDTH)
//   - tx_state_e     : transmitter FSM states (IDLE, HDR, PAY, CHK)
//   - build_header   : packs dest / class / source id into a header flit
// Header layout, from MSB down: dest (DW bits), class (3 bits),
// source id (DW bits), then zero fill.
// ---------------------------------------------------------------------------
package peripheral_noc_pkg;

  localparam int CLASS_WIDTH   = 3;
  localparam int HDR_MAX_WIDTH = 256;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_PAY  = 2'd2,
    ST_CHK  = 2'd3
  } tx_state_e;

  // Flit and id widths are module parameters, so the header is built in a
  // wide working vector and the caller keeps the low flit_width bits.
  function automatic logic [HDR_MAX_WIDTH-1:0] build_header(
    input int                       flit_width,
    input int                       dest_width,
    input logic [HDR_MAX_WIDTH-1:0] dest,
    input logic [CLASS_WIDTH-1:0]   cls,
    input logic [HDR_MAX_WIDTH-1:0] src
  );
    logic [HDR_MAX_WIDTH-1:0] id_mask;
    logic [HDR_MAX_WIDTH-1:0] hdr;
    id_mask = (HDR_MAX_WIDTH'(1) << dest_width) - HDR_MAX_WIDTH'(1);
    hdr = ((dest & id_mask) << (flit_width - dest_width))
        | (HDR_MAX_WIDTH'(cls) << (flit_width - dest_width - CLASS_WIDTH))
        | ((src & id_mask) << (flit_width - 2 * dest_width - CLASS_WIDTH));
    return hdr;
  endfunction

endpackage

// File: rtl/peripheral_noc_packet_tx_outreg.sv
// ---------------------------------------------------------------------------
// peripheral_noc_packet_tx_outreg
// One-entry valid/ready output register carrying a flit, its last flag and
// the VC it travels on. Loads whenever empty or when the held flit is being
// accepted in the same cycle, so back-to-back flits see no bubble.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   load_valid   producer has a flit to load
//   load_flit    flit to load
//   load_last    last flag to load
//   load_vc      VC tag to load
//   load_ready   register can take a flit this cycle
//   out_flit     held flit
//   out_last     held last flag
//   out_valid    one-hot valid on the held VC (zero when empty)
//   out_ready    per-VC ready from the router
// ---------------------------------------------------------------------------
module peripheral_noc_packet_tx_outreg #(
  parameter int FLIT_WIDTH = 32,
  parameter int VCHANNELS  = 1,
  parameter int VC_WIDTH   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_valid,
  input  logic [FLIT_WIDTH-1:0] load_flit,
  input  logic                  load_last,
  input  logic [VC_WIDTH-1:0]   load_vc,
  output logic                  load_ready,
  output logic [FLIT_WIDTH-1:0] out_flit,
  output logic                  out_last,
  output logic [VCHANNELS-1:0]  out_valid,
  input  logic [VCHANNELS-1:0]  out_ready
);

  logic                 full;
  logic [VC_WIDTH-1:0]  vc_q;
  logic                 sel_ready;
  logic [VCHANNELS-1:0] vc_mask;

  // Only the ready of the VC we are holding matters; the others are ignored.
  always_comb begin
    sel_ready = 1'b0;
    vc_mask   = '0;
    for (int v = 0; v < VCHANNELS; v++) begin
      if (vc_q == VC_WIDTH'(v)) begin
        sel_ready  = out_ready[v];
        vc_mask[v] = 1'b1;
      end
    end
  end

  assign load_ready = !full || sel_ready;
  assign out_valid  = full ? vc_mask : '0;

  // Flit, last and VC change only on a load, so they stay stable while the
  // router stalls the held flit.
  always_ff @(posedge clk) begin
    if (rst) begin
      full     <= 1'b0;
      vc_q     <= '0;
      out_flit <= '0;
      out_last <= 1'b0;
    end else if (load_valid && load_ready) begin
      full     <= 1'b1;
      vc_q     <= load_vc;
      out_flit <= load_flit;
      out_last <= load_last;
    end else if (full && sel_ready) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/peripheral_noc_packet_tx.sv
// ---------------------------------------------------------------------------
// peripheral_noc_packet_tx
// NoC endpoint transmitter: accepts a packet request (dest, class, VC,
// length) and a payload word stream, and emits a header flit followed by the
// payload flits on one VC, with last marking the final flit.
// Optional feature macro: PERIPHERAL_NOC_PACKET_TX_CHECKSUM_EN
//   When defined, a trailer flit holding the XOR of all payload words is
//   appended and carries last; header and payload never carry last.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   req_*        packet request (valid/ready, dest, class, vc, len)
//   data_flit    payload word, with data_valid / data_ready handshake
//   out_flit     flit to the router input port
//   out_last     final flit of the packet
//   out_valid    one-hot (or zero) valid per VC
//   out_ready    router ready per VC
// ---------------------------------------------------------------------------
module peripheral_noc_packet_tx
  import peripheral_noc_pkg::*;
#(
  parameter int FLIT_WIDTH = 32,
  parameter int VCHANNELS  = 1,
  parameter int DEST_WIDTH = 5,
  parameter int SRC_ID     = 0,
  parameter int MAX_LEN    = 16,
  localparam int LEN_WIDTH = $clog2(MAX_LEN + 1),
  localparam int VC_WIDTH  = (VCHANNELS > 1) ? $clog2(VCHANNELS) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [DEST_WIDTH-1:0]  req_dest,
  input  logic [CLASS_WIDTH-1:0] req_class,
  input  logic [VC_WIDTH-1:0]    req_vc,
  input  logic [LEN_WIDTH-1:0]   req_len,
  input  logic [FLIT_WIDTH-1:0]  data_flit,
  input  logic                   data_valid,
  output logic                   data_ready,
  output logic [FLIT_WIDTH-1:0]  out_flit,
  output logic                   out_last,
  output logic [VCHANNELS-1:0]   out_valid,
  input  logic [VCHANNELS-1:0]   out_ready
);

  tx_state_e                state;
  logic [DEST_WIDTH-1:0]    dest_q;
  logic [CLASS_WIDTH-1:0]   class_q;
  logic [VC_WIDTH-1:0]      vc_q;
  logic [LEN_WIDTH-1:0]     len_q;
  logic [LEN_WIDTH-1:0]     cnt;
  logic [LEN_WIDTH-1:0]     last_idx;
  logic [LEN_WIDTH-1:0]     len_clamped;
  logic [FLIT_WIDTH-1:0]    header_flit;
  logic                     load_valid;
  logic [FLIT_WIDTH-1:0]    load_flit;
  logic                     load_last;
  logic                     load_ready;
`ifdef PERIPHERAL_NOC_PACKET_TX_CHECKSUM_EN
  logic [FLIT_WIDTH-1:0]    xor_q;
`endif

  assign len_clamped = (req_len > LEN_WIDTH'(MAX_LEN)) ? LEN_WIDTH'(MAX_LEN) : req_len;
  assign last_idx    = len_q - LEN_WIDTH'(1);
  assign header_flit = FLIT_WIDTH'(build_header(FLIT_WIDTH, DEST_WIDTH,
                                                HDR_MAX_WIDTH'(dest_q), class_q,
                                                HDR_MAX_WIDTH'(SRC_ID)));
  assign data_ready  = (state == ST_PAY) && load_ready;

  // Selects what the output register should load in the current state.
  always_comb begin
    load_valid = 1'b0;
    load_flit  = '0;
    load_last  = 1'b0;
    case (state)
      ST_HDR: begin
        load_valid = 1'b1;
        load_flit  = header_flit;
`ifdef PERIPHERAL_NOC_PACKET_TX_CHECKSUM_EN
        load_last  = 1'b0;
`else
        load_last  = (len_q == '0);
`endif
      end
      ST_PAY: begin
        load_valid = data_valid;
        load_flit  = data_flit;
`ifdef PERIPHERAL_NOC_PACKET_TX_CHECKSUM_EN
        load_last  = 1'b0;
`else
        load_last  = (cnt == last_idx);
`endif
      end
      ST_CHK: begin
`ifdef PERIPHERAL_NOC_PACKET_TX_CHECKSUM_EN
        load_valid = 1'b1;
        load_flit  = xor_q;
        load_last  = 1'b1;
`endif
      end
      default: begin
      end
    endcase
  end

  // Packet sequencing. req_ready is held as a register that is set on every
  // transition back into IDLE, so a new request is taken only once the
  // previous packet has fully loaded into the output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      req_ready <= 1'b1;
      dest_q    <= '0;
      class_q   <= '0;
      vc_q      <= '0;
      len_q     <= '0;
      cnt       <= '0;
`ifdef PERIPHERAL_NOC_PACKET_TX_CHECKSUM_EN
      xor_q     <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            dest_q    <= req_dest;
            class_q   <= req_class;
            vc_q      <= req_vc;
            len_q     <= len_clamped;
            cnt       <= '0;
`ifdef PERIPHERAL_NOC_PACKET_TX_CHECKSUM_EN
            xor_q     <= '0;
`endif
            req_ready <= 1'b0;
            state     <= ST_HDR;
          end
        end
        ST_HDR: begin
          if (load_ready) begin
            if (len_q != '0) begin
              state <= ST_PAY;
            end else begin
`ifdef PERIPHERAL_NOC_PACKET_TX_CHECKSUM_EN
              state     <= ST_CHK;
`else
              state     <= ST_IDLE;
              req_ready <= 1'b1;
`endif
            end
          end
        end
        ST_PAY: begin
          if (data_valid && load_ready) begin
            cnt <= cnt + LEN_WIDTH'(1);
`ifdef PERIPHERAL_NOC_PACKET_TX_CHECKSUM_EN
            xor_q <= xor_q ^ data_flit;
`endif
            if (cnt == last_idx) begin
`ifdef PERIPHERAL_NOC_PACKET_TX_CHECKSUM_EN
              state     <= ST_CHK;
`else
              state     <= ST_IDLE;
              req_ready <= 1'b1;
`endif
            end
          end
        end
        ST_CHK: begin
          if (load_ready) begin
            state     <= ST_IDLE;
            req_ready <= 1'b1;
          end
        end
        default: begin
          state     <= ST_IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

  peripheral_noc_packet_tx_outreg #(
    .FLIT_WIDTH (FLIT_WIDTH),
    .VCHANNELS  (VCHANNELS),
    .VC_WIDTH   (VC_WIDTH)
  ) u_outreg (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_flit  (load_flit),
    .load_last  (load_last),
    .load_vc    (vc_q),
    .load_ready (load_ready),
    .out_flit   (out_flit),
    .out_last   (out_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
  );

endmodule

// File: tb/tb_peripheral_noc_packet_tx.sv
// ---------------------------------------------------------------------------
// tb_peripheral_noc_packet_tx
// Directed bench for the NoC packet transmitter with two VCs, SRC_ID=1.
// Expected flits are pushed to a scoreboard queue when a request is issued
// and popped by a negedge monitor on every output handshake.
// ---------------------------------------------------------------------------
module tb_peripheral_noc_packet_tx;

  localparam int FW  = 32;
  localparam int VCS = 2;
  localparam int DW  = 5;
  localparam int SRC = 1;
  localparam int ML  = 16;
`ifdef PERIPHERAL_NOC_PACKET_TX_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  typedef struct {
    logic [FW-1:0] flit;
    logic          last;
    int            vc;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst;
  logic           req_valid;
  logic           req_ready;
  logic [DW-1:0]  req_dest;
  logic [2:0]     req_class;
  logic [0:0]     req_vc;
  logic [4:0]     req_len;
  logic [FW-1:0]  data_flit;
  logic           data_valid;
  logic           data_ready;
  logic [FW-1:0]  out_flit;
  logic           out_last;
  logic [VCS-1:0] out_valid;
  logic [VCS-1:0] out_ready;

  exp_t          sb[$];
  logic [FW-1:0] pay [16];
  int            n_assert = 0;
  int            n_fail   = 0;
  int            cyc      = 0;
  int            hs_cnt   = 0;
  int            first_hs = 0;
  int            last_hs  = 0;
  bit            mon_en   = 1'b0;
  int            ready_mode = 0;
  bit            stall_pending = 1'b0;
  logic [VCS-1:0] held_valid;
  logic [FW-1:0]  held_flit;
  logic           held_last;

  peripheral_noc_packet_tx #(
    .FLIT_WIDTH (FW),
    .VCHANNELS  (VCS),
    .DEST_WIDTH (DW),
    .SRC_ID     (SRC),
    .MAX_LEN    (ML)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_dest   (req_dest),
    .req_class  (req_class),
    .req_vc     (req_vc),
    .req_len    (req_len),
    .data_flit  (data_flit),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .out_flit   (out_flit),
    .out_last   (out_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Independent header model: dest | class | src | zero fill.
  function automatic logic [FW-1:0] hdrModel(input logic [DW-1:0] d, input logic [2:0] c);
    logic [DW-1:0] s;
    s = DW'(SRC);
    return {d, c, s, 19'd0};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Router-side ready driver: mode 0 always ready, mode 1 keeps VC0 ready
  // and toggles VC1 every cycle.
  initial begin
    bit tog;
    tog = 1'b0;
    out_ready = '1;
    forever begin
      @(posedge clk);
      #1;
      if (ready_mode == 1) begin
        tog = ~tog;
        out_ready = {tog, 1'b1};
      end else begin
        out_ready = '1;
      end
    end
  end

  // Output monitor: stability of stalled flits, and scoreboard compare on
  // every handshake.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (stall_pending) begin
        checkOutput("stall_valid", 64'(out_valid), 64'(held_valid));
        checkOutput("stall_flit", 64'(out_flit), 64'(held_flit));
        checkOutput("stall_last", 64'(out_last), 64'(held_last));
        stall_pending = 1'b0;
      end
      if (out_valid != '0) begin
        if ((out_valid & out_ready) != '0) begin
          if (sb.size() == 0) begin
            checkOutput("extra_flit", 64'(out_valid), 64'd0);
          end else begin
            exp_t e;
            logic [VCS-1:0] ov;
            e  = sb.pop_front();
            ov = VCS'(1) << e.vc;
            checkOutput("flit", 64'(out_flit), 64'(e.flit));
            checkOutput("last", 64'(out_last), 64'(e.last));
            checkOutput("vc_valid", 64'(out_valid), 64'(ov));
            if (hs_cnt == 0) first_hs = cyc;
            last_hs = cyc;
            hs_cnt++;
          end
        end else begin
          held_valid    = out_valid;
          held_flit     = out_flit;
          held_last     = out_last;
          stall_pending = 1'b1;
        end
      end
    end
  end

  task automatic sendWord(input logic [FW-1:0] w, input bit gap);
    bit hs;
    int budget;
    if (gap) begin
      data_valid = 1'b0;
      @(posedge clk);
      #1;
    end
    data_valid = 1'b1;
    data_flit  = w;
    hs = 1'b0;
    budget = 0;
    while (!hs && budget < 200) begin
      @(negedge clk);
      hs = data_ready;
      @(posedge clk);
      #1;
      budget++;
    end
    if (!hs) checkOutput("data_ready_timeout", 64'(data_ready), 64'd1);
  endtask

  // Issues one request with payload taken from pay[], pushing the expected
  // flit sequence first.
  task automatic applyStimulus(input logic [DW-1:0] d, input logic [2:0] c,
                               input logic v, input int len, input bit gaps);
    int eff;
    bit hs;
    int budget;
    logic [FW-1:0] x;
    eff = (len > ML) ? ML : len;
    x = '0;
    sb.push_back('{hdrModel(d, c), CK ? 1'b0 : (eff == 0), int'(v)});
    for (int i = 0; i < eff; i++) begin
      x ^= pay[i];
      sb.push_back('{pay[i], !CK && (i == eff - 1), int'(v)});
    end
    if (CK) sb.push_back('{x, 1'b1, int'(v)});
    req_valid = 1'b1;
    req_dest  = d;
    req_class = c;
    req_vc    = v;
    req_len   = 5'(len);
    hs = 1'b0;
    budget = 0;
    while (!hs && budget < 200) begin
      @(negedge clk);
      hs = req_ready;
      @(posedge clk);
      #1;
      budget++;
    end
    req_valid = 1'b0;
    if (!hs) checkOutput("req_ready_timeout", 64'(req_ready), 64'd1);
    for (int i = 0; i < eff; i++) sendWord(pay[i], gaps && (i % 2 == 1));
    data_valid = 1'b0;
  endtask

  task automatic waitDrain();
    int budget;
    budget = 0;
    while (!(sb.size() == 0 && out_valid == '0) && budget < 300) begin
      @(posedge clk);
      #1;
      budget++;
    end
    checkOutput("drain", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_dest = '0; req_class = '0; req_vc = '0;
    req_len = '0; data_flit = '0; data_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Test 1: reset in the middle of a packet.
    req_valid = 1'b1; req_dest = 5'd3; req_class = 3'd1; req_vc = 1'b0; req_len = 5'd4;
    @(posedge clk);
    #1;
    req_valid = 1'b0; data_valid = 1'b1; data_flit = 32'hDEAD_0001;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_req_ready", 64'(req_ready), 64'd1);
    checkOutput("rst_data_ready", 64'(data_ready), 64'd0);
    checkOutput("rst_out_last", 64'(out_last), 64'd0);
    checkOutput("rst_out_flit", 64'(out_flit), 64'd0);
    rst = 1'b0; data_valid = 1'b0;
    @(posedge clk);
    #1;
    mon_en = 1'b1;

    // Test 2: dest 5, class 2, len 3 on VC0, no bubbles.
    pay[0] = 32'h1111_0000; pay[1] = 32'h2222_0000; pay[2] = 32'h3333_0000;
    hs_cnt = 0;
    applyStimulus(5'd5, 3'd2, 1'b0, 3, 1'b0);
    waitDrain();
    checkOutput("t2_flit_count", 64'(hs_cnt), CK ? 64'd5 : 64'd4);
    checkOutput("t2_no_bubble", 64'(last_hs - first_hs), CK ? 64'd4 : 64'd3);

    // Test 3: zero-length packet.
    applyStimulus(5'd9, 3'd7, 1'b0, 0, 1'b0);
    waitDrain();

    // Test 4: VC1 with toggling ready on VC1 only.
    ready_mode = 1;
    pay[0] = 32'hA5A5_0001; pay[1] = 32'h5A5A_0002;
    applyStimulus(5'd17, 3'd4, 1'b1, 2, 1'b0);
    waitDrain();
    ready_mode = 0;

    // Test 5: two back-to-back len=2 requests.
    pay[0] = $urandom; pay[1] = $urandom;
    applyStimulus(5'd2, 3'd1, 1'b0, 2, 1'b0);
    pay[0] = $urandom; pay[1] = $urandom;
    applyStimulus(5'd30, 3'd3, 1'b1, 2, 1'b0);
    waitDrain();

    // Test 6: payload 1,2,4 with data gaps (trailer 0x7 when checksum on).
    pay[0] = 32'h1; pay[1] = 32'h2; pay[2] = 32'h4;
    applyStimulus(5'd1, 3'd0, 1'b0, 3, 1'b1);
    waitDrain();

    // Length above MAX_LEN is clamped to 16 payload flits.
    for (int i = 0; i < 16; i++) pay[i] = 32'hC000_0000 + 32'(i * 7);
    applyStimulus(5'd31, 3'd5, 1'b1, 20, 1'b0);
    waitDrain();

    checkOutput("final_req_ready", 64'(req_ready), 64'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
